// File: rtl/types_pkg.sv
// Shared rename/recovery types and physical register
// table sizing.
package types_pkg;

  localparam int NUM_PREGS = 128;
  localparam int PREG_W    = 7;
  localparam int CHUNK_W   = 32;

  typedef struct packed {
    logic [NUM_PREGS-1:0] reset_reg_rdy_table;
  } checkpoint;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } prt_state_e;

endpackage

// File: rtl/preg_ready_table_if.sv
// Ready-table bundle: rename/CDB/dispatch side
// plus mispredict snapshot and status.
interface preg_ready_table_if;
  import types_pkg::*;

  logic                 alloc_valid;
  logic [PREG_W-1:0]    alloc_pr;
  logic                 wb_valid;
  logic [PREG_W-1:0]    wb_pr;
  logic [PREG_W-1:0]    rs1_pr;
  logic [PREG_W-1:0]    rs2_pr;
  logic                 checkpoint_valid;
  checkpoint            snapshot;
  logic                 rs1_rdy;
  logic                 rs2_rdy;
  logic                 busy;
  logic                 recover_done;
  logic [NUM_PREGS-1:0] rdy_table;

  modport master (
    output alloc_valid, alloc_pr,
    output wb_valid, wb_pr,
    output rs1_pr, rs2_pr,
    output checkpoint_valid, snapshot,
    input  rs1_rdy, rs2_rdy,
    input  busy, recover_done,
    input  rdy_table
  );

  modport slave (
    input  alloc_valid, alloc_pr,
    input  wb_valid, wb_pr,
    input  rs1_pr, rs2_pr,
    input  checkpoint_valid, snapshot,
    output rs1_rdy, rs2_rdy,
    output busy, recover_done,
    output rdy_table
  );

endinterface

// File: rtl/preg_ready_table.sv
// Physical register ready bits with CDB bypass and
// 4-cycle chunked restore after a mispredict.
module preg_ready_table
  import types_pkg::*;
(
  input logic         clk,
  input logic         reset,
  preg_ready_table_if.slave bus
);

  logic [NUM_PREGS-1:0] table_q, table_d;
  logic [NUM_PREGS-1:0] mask_q, mask_d;
  prt_state_e           state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [PREG_W-1:0]    base;
  logic                 ckpt;

  assign ckpt = bus.checkpoint_valid;
  assign base = {cnt_q, 5'b0};

  always_comb begin
    table_d = table_q;
    mask_d  = mask_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ckpt) begin
          mask_d  = bus.snapshot.reset_reg_rdy_table;
          cnt_d   = 2'd0;
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        table_d[base +: CHUNK_W] =
          table_q[base +: CHUNK_W] |
          mask_q[base +: CHUNK_W];
        if (ckpt) begin
          // newer mispredict: merge and restart
          mask_d = mask_q |
            bus.snapshot.reset_reg_rdy_table;
          cnt_d  = 2'd0;
        end else if (cnt_q == 2'd3) begin
          cnt_d   = 2'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
    if (bus.wb_valid)
      table_d[bus.wb_pr] = 1'b1;
    // clear after set: the allocation is newer
    if (state_q == IDLE && bus.alloc_valid && !ckpt)
      table_d[bus.alloc_pr] = 1'b0;
    table_d[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      table_q <= '1;
      mask_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      table_q <= table_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.rs1_rdy = table_q[bus.rs1_pr] |
    (bus.wb_valid && bus.wb_pr == bus.rs1_pr) |
    (bus.rs1_pr == '0);
  assign bus.rs2_rdy = table_q[bus.rs2_pr] |
    (bus.wb_valid && bus.wb_pr == bus.rs2_pr) |
    (bus.rs2_pr == '0);

  assign bus.busy = (state_q == RECOVER);
  assign bus.recover_done =
    (state_q == RECOVER) && (cnt_q == 2'd3);
  assign bus.rdy_table = table_q;

endmodule

// File: tb/tb_preg_ready_table.sv
// Directed scoreboard bench for preg_ready_table.
// Expectations queued by stimulus, checked at negedge.
module tb_preg_ready_table;
  import types_pkg::*;

  localparam int K_RS1  = 0;
  localparam int K_RS2  = 1;
  localparam int K_BUSY = 2;
  localparam int K_DONE = 3;
  localparam int K_TBIT = 4;
  localparam int K_TAB  = 5;

  typedef struct {
    string        name;
    int           kind;
    int           idx;
    logic [127:0] exp;
  } chk_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  chk_t sb_q[$];

  preg_ready_table_if bus ();

  preg_ready_table dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string n,
                      input int k, input int i,
                      input logic [127:0] e);
    chk_t c;
    c.name = n;
    c.kind = k;
    c.idx  = i;
    c.exp  = e;
    sb_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_one(input int pr);
    bus.alloc_valid = 1'b1;
    bus.alloc_pr    = 7'(pr);
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  function automatic logic [127:0] actual(
    input int k, input int i);
    logic [127:0] a;
    a = '0;
    case (k)
      K_RS1:  a[0] = bus.rs1_rdy;
      K_RS2:  a[0] = bus.rs2_rdy;
      K_BUSY: a[0] = bus.busy;
      K_DONE: a[0] = bus.recover_done;
      K_TBIT: a[0] = bus.rdy_table[i];
      default: a = bus.rdy_table;
    endcase
    return a;
  endfunction

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      chk_t c;
      logic [127:0] a;
      c = sb_q.pop_front();
      a = actual(c.kind, c.idx);
      checks++;
      if (a !== c.exp) begin
        errors++;
        $display("FAIL %s got=%0h want=%0h",
                 c.name, a, c.exp);
      end
    end
  end

  logic [127:0] ones;
  logic [127:0] m;

  initial begin
    errors = 0;
    checks = 0;
    ones = '1;
    reset = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.alloc_pr = '0;
    bus.wb_valid = 1'b0;
    bus.wb_pr = '0;
    bus.rs1_pr = '0;
    bus.rs2_pr = '0;
    bus.checkpoint_valid = 1'b0;
    bus.snapshot = '0;
    #12 reset = 1'b1;
    tick();

    // reset state
    bus.rs1_pr = 7'd5;
    bus.rs2_pr = 7'd127;
    push("rst_rs1", K_RS1, 0, 1);
    push("rst_rs2", K_RS2, 0, 1);
    push("rst_busy", K_BUSY, 0, 0);
    push("rst_done", K_DONE, 0, 0);
    push("rst_table", K_TAB, 0, ones);
    tick();

    // alloc then writeback with bypass
    bus.rs1_pr = 7'd40;
    push("pre_alloc_rs1", K_RS1, 0, 1);
    alloc_one(40);
    push("alloc_rs1", K_RS1, 0, 0);
    push("alloc_t40", K_TBIT, 40, 0);
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_pr = 7'd40;
    push("bypass_rs1", K_RS1, 0, 1);
    push("bypass_t40", K_TBIT, 40, 0);
    tick();
    bus.wb_valid = 1'b0;
    push("wb_t40", K_TBIT, 40, 1);
    push("wb_rs1", K_RS1, 0, 1);

    // same-cycle conflict: clear wins
    bus.rs2_pr = 7'd17;
    bus.wb_valid = 1'b1;
    bus.wb_pr = 7'd17;
    push("conf_byp_rs2", K_RS2, 0, 1);
    alloc_one(17);
    bus.wb_valid = 1'b0;
    push("conf_t17", K_TBIT, 17, 0);
    push("conf_rs2", K_RS2, 0, 0);

    // PR 0 always ready
    bus.rs1_pr = 7'd0;
    alloc_one(0);
    push("pr0_t0", K_TBIT, 0, 1);
    push("pr0_rs1", K_RS1, 0, 1);

    // recovery
    alloc_one(10);
    alloc_one(45);
    alloc_one(70);
    alloc_one(120);
    push("pre_t10", K_TBIT, 10, 0);
    push("pre_t120", K_TBIT, 120, 0);
    m = '0;
    m[45] = 1'b1;
    m[70] = 1'b1;
    m[120] = 1'b1;
    bus.snapshot.reset_reg_rdy_table = m;
    bus.checkpoint_valid = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.alloc_pr = 7'd99;
    push("e0_busy", K_BUSY, 0, 0);
    tick();
    bus.checkpoint_valid = 1'b0;
    bus.alloc_pr = 7'd100;
    push("rc1_busy", K_BUSY, 0, 1);
    push("rc1_done", K_DONE, 0, 0);
    push("drop_t99", K_TBIT, 99, 1);
    tick();
    push("rc2_busy", K_BUSY, 0, 1);
    push("rc2_done", K_DONE, 0, 0);
    tick();
    push("rc3_busy", K_BUSY, 0, 1);
    push("rc3_done", K_DONE, 0, 0);
    push("rc3_t45", K_TBIT, 45, 1);
    push("rc3_t70", K_TBIT, 70, 0);
    tick();
    push("rc4_busy", K_BUSY, 0, 1);
    push("rc4_done", K_DONE, 0, 1);
    tick();
    bus.alloc_valid = 1'b0;
    push("rc5_busy", K_BUSY, 0, 0);
    push("rc5_done", K_DONE, 0, 0);
    push("rc_t45", K_TBIT, 45, 1);
    push("rc_t70", K_TBIT, 70, 1);
    push("rc_t120", K_TBIT, 120, 1);
    push("rc_t10", K_TBIT, 10, 0);
    push("rc_t100", K_TBIT, 100, 1);

    // back-to-back mispredict
    alloc_one(45);
    alloc_one(70);
    alloc_one(120);
    bus.checkpoint_valid = 1'b1;
    tick();
    bus.checkpoint_valid = 1'b0;
    push("bb1_busy", K_BUSY, 0, 1);
    tick();
    push("bb2_busy", K_BUSY, 0, 1);
    tick();
    m = '0;
    m[10] = 1'b1;
    bus.snapshot.reset_reg_rdy_table = m;
    bus.checkpoint_valid = 1'b1;
    push("bb3_done", K_DONE, 0, 0);
    tick();
    bus.checkpoint_valid = 1'b0;
    push("bb4_busy", K_BUSY, 0, 1);
    push("bb4_t120", K_TBIT, 120, 0);
    push("bb4_t10", K_TBIT, 10, 0);
    tick();
    push("bb5_t10", K_TBIT, 10, 1);
    push("bb5_done", K_DONE, 0, 0);
    tick();
    push("bb6_busy", K_BUSY, 0, 1);
    tick();
    push("bb7_busy", K_BUSY, 0, 1);
    push("bb7_done", K_DONE, 0, 1);
    tick();
    push("bb8_busy", K_BUSY, 0, 0);
    push("bb_t10", K_TBIT, 10, 1);
    push("bb_t45", K_TBIT, 45, 1);
    push("bb_t70", K_TBIT, 70, 1);
    push("bb_t120", K_TBIT, 120, 1);

    // async reset mid-recovery
    alloc_one(10);
    alloc_one(45);
    m = '0;
    m[45] = 1'b1;
    bus.snapshot.reset_reg_rdy_table = m;
    bus.checkpoint_valid = 1'b1;
    tick();
    bus.checkpoint_valid = 1'b0;
    push("ar1_busy", K_BUSY, 0, 1);
    tick();
    #2 reset = 1'b0;
    push("ar_busy", K_BUSY, 0, 0);
    push("ar_done", K_DONE, 0, 0);
    push("ar_table", K_TAB, 0, ones);
    @(negedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      push("ar_post_done", K_DONE, 0, 0);
      push("ar_post_busy", K_BUSY, 0, 0);
    end
    push("ar_post_table", K_TAB, 0, ones);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0",
               sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
